// File: rtl/lu_block_sched_if.sv
// Host/dispatcher bundle for the blocked-LU block scheduler.
// master = scheduler side, slave = host control plus compute-lane dispatcher.
interface lu_block_sched_if #(
  parameter int BDIM_BITS = 8
);
  logic                 i_start;
  logic [BDIM_BITS-1:0] i_bdim_m1;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_cmd_valid;
  logic                 i_cmd_ready;
  logic [1:0]           o_cmd_mode;
  logic [BDIM_BITS-1:0] o_cmd_k;
  logic [BDIM_BITS-1:0] o_cmd_row;
  logic [BDIM_BITS-1:0] o_cmd_col;
  logic [2:0]           o_cmd_buf;
  logic                 i_cmd_done;
  logic                 o_err;
  logic [31:0]          o_stall_cycles;

  modport master (
    input  i_start, i_bdim_m1, i_cmd_ready, i_cmd_done,
    output o_busy, o_done, o_cmd_valid, o_cmd_mode, o_cmd_k, o_cmd_row,
           o_cmd_col, o_cmd_buf, o_err, o_stall_cycles
  );

  modport slave (
    output i_start, i_bdim_m1, i_cmd_ready, i_cmd_done,
    input  o_busy, o_done, o_cmd_valid, o_cmd_mode, o_cmd_k, o_cmd_row,
           o_cmd_col, o_cmd_buf, o_err, o_stall_cycles
  );
endinterface

// File: rtl/lu_block_sched.sv
// Blocked-LU task scheduler: walks diag/panel/interior block operations per step k
// with outstanding-command barriers. Optional LU_SCHED_PERF_EN adds a stall-cycle counter.
module lu_block_sched #(
  parameter int BDIM_BITS       = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int OUT_BITS        = 5
) (
  input logic              clk,
  input logic              reset,
  lu_block_sched_if.master bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIAG  = 3'd1,
    WAIT1 = 3'd2,
    PANEL = 3'd3,
    WAIT2 = 3'd4,
    INNER = 3'd5,
    WAIT3 = 3'd6,
    FIN   = 3'd7
  } state_t;

  localparam logic [BDIM_BITS-1:0] B_ZERO  = {BDIM_BITS{1'b0}};
  localparam logic [BDIM_BITS-1:0] B_ONE   = {{(BDIM_BITS-1){1'b0}}, 1'b1};
  localparam logic [OUT_BITS-1:0]  C_ZERO  = {OUT_BITS{1'b0}};
  localparam logic [OUT_BITS-1:0]  C_ONE   = {{(OUT_BITS-1){1'b0}}, 1'b1};
  localparam logic [OUT_BITS-1:0]  MAX_OUT = OUT_BITS'(MAX_OUTSTANDING);
  localparam logic [1:0] MODE_DIAG  = 2'd0;
  localparam logic [1:0] MODE_ROW   = 2'd1;
  localparam logic [1:0] MODE_COL   = 2'd2;
  localparam logic [1:0] MODE_INNER = 2'd3;
  localparam logic [2:0] BUF_DIAG   = 3'b100;
  localparam logic [2:0] BUF_ROW    = 3'b110;
  localparam logic [2:0] BUF_COL    = 3'b101;
  localparam logic [2:0] BUF_INNER  = 3'b111;

  state_t               state_r, state_s;
  logic [BDIM_BITS-1:0] nm1_r, nm1_s, k_r, k_s, row_r, row_s, col_r, col_s;
  logic [1:0]           mode_r, mode_s;
  logic [2:0]           buf_r, buf_s;
  logic                 valid_r, valid_s, busy_r, busy_s, done_r, done_s;
  logic [OUT_BITS-1:0]  cnt_r, cnt_s;
  logic                 err_r, err_s;
  logic                 fire_s, credit_s;

  assign fire_s   = valid_r && bus.i_cmd_ready;
  assign credit_s = (cnt_s < MAX_OUT);

  // Outstanding-command accounting and sticky underflow error
  always_comb begin
    cnt_s = cnt_r;
    err_s = err_r;
    if (fire_s && !bus.i_cmd_done) begin
      cnt_s = cnt_r + C_ONE;
    end else if (!fire_s && bus.i_cmd_done) begin
      if (cnt_r == C_ZERO) begin
        err_s = 1'b1;
      end else begin
        cnt_s = cnt_r - C_ONE;
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Schedule walk: next state, next command fields and status flags
  always_comb begin
    state_s = state_r;
    nm1_s   = nm1_r;
    k_s     = k_r;
    row_s   = row_r;
    col_s   = col_r;
    mode_s  = mode_r;
    buf_s   = buf_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.i_start) begin
          nm1_s   = bus.i_bdim_m1;
          k_s     = B_ZERO;
          row_s   = B_ZERO;
          col_s   = B_ZERO;
          mode_s  = MODE_DIAG;
          buf_s   = BUF_DIAG;
          valid_s = credit_s;
          busy_s  = 1'b1;
          state_s = DIAG;
        end else begin
          state_s = IDLE;
        end
      end
      DIAG: begin
        if (fire_s) begin
          valid_s = 1'b0;
          state_s = WAIT1;
        end else begin
          valid_s = valid_r || credit_s;
        end
      end
      WAIT1: begin
        if (cnt_r != C_ZERO) begin
          state_s = WAIT1;
        end else if (k_r == nm1_r) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = FIN;
        end else begin
          row_s   = k_r;
          col_s   = k_r + B_ONE;
          mode_s  = MODE_ROW;
          buf_s   = BUF_ROW;
          valid_s = credit_s;
          state_s = PANEL;
        end
      end
      PANEL: begin
        // Row pass flows straight into the column pass without a barrier
        if (!fire_s) begin
          valid_s = valid_r || credit_s;
        end else if (mode_r == MODE_ROW) begin
          if (col_r == nm1_r) begin
            row_s  = k_r + B_ONE;
            col_s  = k_r;
            mode_s = MODE_COL;
            buf_s  = BUF_COL;
          end else begin
            col_s = col_r + B_ONE;
          end
          valid_s = credit_s;
        end else if (row_r == nm1_r) begin
          valid_s = 1'b0;
          state_s = WAIT2;
        end else begin
          row_s   = row_r + B_ONE;
          valid_s = credit_s;
        end
      end
      WAIT2: begin
        if (cnt_r == C_ZERO) begin
          row_s   = k_r + B_ONE;
          col_s   = k_r + B_ONE;
          mode_s  = MODE_INNER;
          buf_s   = BUF_INNER;
          valid_s = credit_s;
          state_s = INNER;
        end else begin
          state_s = WAIT2;
        end
      end
      INNER: begin
        if (!fire_s) begin
          valid_s = valid_r || credit_s;
        end else if (col_r != nm1_r) begin
          col_s   = col_r + B_ONE;
          valid_s = credit_s;
        end else if (row_r != nm1_r) begin
          row_s   = row_r + B_ONE;
          col_s   = k_r + B_ONE;
          valid_s = credit_s;
        end else begin
          valid_s = 1'b0;
          state_s = WAIT3;
        end
      end
      WAIT3: begin
        if (cnt_r == C_ZERO) begin
          k_s     = k_r + B_ONE;
          row_s   = k_r + B_ONE;
          col_s   = k_r + B_ONE;
          mode_s  = MODE_DIAG;
          buf_s   = BUF_DIAG;
          valid_s = credit_s;
          state_s = DIAG;
        end else begin
          state_s = WAIT3;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, command and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      nm1_r   <= B_ZERO;
      k_r     <= B_ZERO;
      row_r   <= B_ZERO;
      col_r   <= B_ZERO;
      mode_r  <= 2'd0;
      buf_r   <= 3'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= C_ZERO;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      nm1_r   <= nm1_s;
      k_r     <= k_s;
      row_r   <= row_s;
      col_r   <= col_s;
      mode_r  <= mode_s;
      buf_r   <= buf_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
    end
  end

  assign bus.o_busy      = busy_r;
  assign bus.o_done      = done_r;
  assign bus.o_cmd_valid = valid_r;
  assign bus.o_cmd_mode  = mode_r;
  assign bus.o_cmd_k     = k_r;
  assign bus.o_cmd_row   = row_r;
  assign bus.o_cmd_col   = col_r;
  assign bus.o_cmd_buf   = buf_r;
  assign bus.o_err       = err_r;

`ifdef LU_SCHED_PERF_EN
  logic [31:0] stall_r;
  logic        stall_hit_s;

  assign stall_hit_s = (((state_r == WAIT1) || (state_r == WAIT2) || (state_r == WAIT3))
                        && (cnt_r != C_ZERO)) || (valid_r && !bus.i_cmd_ready);

  // Saturating barrier/backpressure stall counter, cleared on accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_r <= 32'd0;
    end else if ((state_r == IDLE) && bus.i_start) begin
      stall_r <= 32'd0;
    end else if (stall_hit_s && (stall_r != 32'hFFFF_FFFF)) begin
      stall_r <= stall_r + 32'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign bus.o_stall_cycles = stall_r;
`else
  assign bus.o_stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_lu_block_sched.sv
// Self-checking bench for lu_block_sched: a queue-based reference schedule plus
// outstanding/barrier bookkeeping, compared against the DUT every cycle.
module tb_lu_block_sched;
  localparam int BB   = 8;
  localparam int MAXO = 4;
  localparam int OB   = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lu_block_sched_if #(.BDIM_BITS(BB)) bus ();

  lu_block_sched #(.BDIM_BITS(BB), .MAX_OUTSTANDING(MAXO), .OUT_BITS(OB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int mode; int k; int row; int col; int bufv; bit first; bit last;
  } cmd_t;

  cmd_t gen_q[$];
  cmd_t exp_q[$];
  int   due_q[$];

  int chk = 0;
  int errs = 0;
  int cyc = 0;
  int dly = 1;
  int rdy_mode = 0;
  bit hold = 1'b0;
  bit force_one = 1'b0;
  bit stray = 1'b0;

  int          m_cnt = 0;
  int          m_fired = 0;
  int          n_done = 0;
  bit          m_err = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_done_now = 1'b0;
  bit          waiting = 1'b0;
  bit          pres_prev = 1'b0;
  logic [31:0] m_stall = 32'd0;
  logic [28:0] cur_f, prev_f, want_f;

  task automatic check(input string name, input longint got, input longint want);
    chk++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic push_cmd(input int m, input int k, input int r, input int c, input int b,
                          input bit f, input bit l);
    cmd_t x;
    x.mode = m; x.k = k; x.row = r; x.col = c; x.bufv = b; x.first = f; x.last = l;
    gen_q.push_back(x);
  endtask

  // Reference schedule from the LU step rules, one group per barrier
  task automatic build(input int nm1);
    gen_q.delete();
    for (int k = 0; k <= nm1; k++) begin
      push_cmd(0, k, k, k, 4, 1'b1, 1'b1);
      if (k < nm1) begin
        for (int j = k + 1; j <= nm1; j++) push_cmd(1, k, k, j, 6, j == k + 1, 1'b0);
        for (int i = k + 1; i <= nm1; i++) push_cmd(2, k, i, k, 5, 1'b0, i == nm1);
        for (int i = k + 1; i <= nm1; i++)
          for (int j = k + 1; j <= nm1; j++)
            push_cmd(3, k, i, j, 7, (i == k + 1) && (j == k + 1), (i == nm1) && (j == nm1));
      end
    end
  endtask

  function automatic logic [28:0] pack(input cmd_t x);
    return {2'(x.mode), 8'(x.k), 8'(x.row), 8'(x.col), 3'(x.bufv)};
  endfunction

  // Input driver: ready pattern and completion pulses
  initial begin
    bus.i_cmd_ready = 1'b0;
    bus.i_cmd_done  = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.i_cmd_done = 1'b0;
      if (reset) begin
        due_q.delete();
      end else if (stray) begin
        bus.i_cmd_done = 1'b1;
        stray = 1'b0;
      end else if (force_one && due_q.size() > 0) begin
        bus.i_cmd_done = 1'b1;
        void'(due_q.pop_front());
        force_one = 1'b0;
      end else if (!hold && due_q.size() > 0 && due_q[0] <= cyc) begin
        bus.i_cmd_done = 1'b1;
        void'(due_q.pop_front());
      end
      case (rdy_mode)
        0: bus.i_cmd_ready = 1'b1;
        1: bus.i_cmd_ready = 1'($urandom_range(0, 1));
        default: bus.i_cmd_ready = 1'b0;
      endcase
    end
  end

  // Compare process: outputs vs model on every falling edge, then advance model
  initial begin
    bit fire, dn, idle_now, nxt_done;
    forever begin
      @(negedge clk);
      cur_f = {bus.o_cmd_mode, bus.o_cmd_k, bus.o_cmd_row, bus.o_cmd_col, bus.o_cmd_buf};
      if (reset) begin
        check("rst_valid", bus.o_cmd_valid, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_err", bus.o_err, 0);
        check("rst_fields", cur_f, 0);
        check("rst_stall", bus.o_stall_cycles, 0);
        exp_q.delete(); due_q.delete();
        m_cnt = 0; m_err = 1'b0; m_busy = 1'b0; m_done_now = 1'b0;
        waiting = 1'b0; pres_prev = 1'b0; m_stall = 32'd0;
      end else begin
        check("busy", bus.o_busy, m_busy);
        check("done", bus.o_done, m_done_now);
        check("err", bus.o_err, m_err);
        check("stall_cycles", bus.o_stall_cycles, m_stall);
        if (bus.o_done) n_done++;
        if (bus.o_cmd_valid) begin
          check("cmd_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            want_f = pack(exp_q[0]);
            check("cmd_fields", cur_f, want_f);
            if (!pres_prev) begin
              check("credit", m_cnt < MAXO, 1);
              if (exp_q[0].first) check("barrier_cnt", m_cnt, 0);
            end
          end
          if (pres_prev) check("hold_fields", cur_f, prev_f);
        end else if (pres_prev) begin
          check("withdrawn", bus.o_cmd_valid, 1);
        end

        fire     = bus.o_cmd_valid && bus.i_cmd_ready;
        dn       = bus.i_cmd_done;
        idle_now = !m_busy && !m_done_now;
        nxt_done = 1'b0;
`ifdef LU_SCHED_PERF_EN
        if (((waiting && m_cnt != 0) || (bus.o_cmd_valid && !bus.i_cmd_ready))
            && m_stall != 32'hFFFF_FFFF)
          m_stall = m_stall + 32'd1;
`endif
        if (waiting && m_cnt == 0) begin
          waiting = 1'b0;
          if (exp_q.size() == 0) nxt_done = 1'b1;
        end
        if (fire && exp_q.size() > 0) begin
          if (exp_q[0].last) waiting = 1'b1;
          void'(exp_q.pop_front());
          m_fired++;
          due_q.push_back(cyc + dly);
        end
        if (fire && !dn) m_cnt++;
        else if (dn && !fire) begin
          if (m_cnt == 0) m_err = 1'b1;
          else m_cnt--;
        end
        pres_prev = bus.o_cmd_valid && !bus.i_cmd_ready;
        prev_f    = cur_f;
        if (nxt_done) m_busy = 1'b0;
        if (bus.i_start && idle_now) begin
          build(int'(bus.i_bdim_m1));
          exp_q   = gen_q;
          m_busy  = 1'b1;
          m_stall = 32'd0;
          m_fired = 0;
        end
        m_done_now = nxt_done;
      end
    end
  end

  task automatic pulse_start(input int nm1);
    @(posedge clk); #1;
    bus.i_bdim_m1 = 8'(nm1);
    bus.i_start   = 1'b1;
    @(posedge clk); #1;
    bus.i_start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n0;
    int t;
    n0 = n_done;
    t  = 0;
    while (n_done == n0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    check({tag, "_done_pulses"}, n_done - n0, 1);
  endtask

  task automatic run(input int nm1, input int d, input int rm, input int want, input string tag);
    dly = d;
    rdy_mode = rm;
    pulse_start(nm1);
    wait_done(tag);
    check({tag, "_transfers"}, m_fired, want);
    check({tag, "_busy_end"}, bus.o_busy, 0);
  endtask

  task automatic wait_mode(input int mode, input string tag);
    int t;
    t = 0;
    while (!(bus.o_cmd_valid && bus.o_cmd_mode == 2'(mode)) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_reached"}, t < 1000, 1);
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    bus.i_start = 1'b0;
    bus.i_bdim_m1 = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Hand-derived pins on the reference schedule
    build(0); check("model_n1_len", gen_q.size(), 1);
    build(2); check("model_n3_len", gen_q.size(), 14);
    check("model_n3_idx5", pack(gen_q[5]), {2'd3, 8'd0, 8'd1, 8'd1, 3'b111});
    check("model_n3_idx9", pack(gen_q[9]), {2'd0, 8'd1, 8'd1, 8'd1, 3'b100});
    check("model_n3_idx11", pack(gen_q[11]), {2'd2, 8'd1, 8'd2, 8'd1, 3'b101});
    check("model_n3_idx13", pack(gen_q[13]), {2'd0, 8'd2, 8'd2, 8'd2, 3'b100});
    build(3); check("model_n4_len", gen_q.size(), 30);

    // N=1: single diag command, completion two cycles after transfer
    dly = 2; rdy_mode = 0;
    pulse_start(0);
    @(negedge clk);
    check("n1_valid", bus.o_cmd_valid, 1);
    check("n1_busy", bus.o_busy, 1);
    check("n1_cmd", {bus.o_cmd_mode, bus.o_cmd_k, bus.o_cmd_row, bus.o_cmd_col, bus.o_cmd_buf},
          {2'd0, 8'd0, 8'd0, 8'd0, 3'b100});
    wait_done("n1");
    check("n1_transfers", m_fired, 1);

    // N=3 with a stray start mid-run that must be ignored
    dly = 1; rdy_mode = 0;
    pulse_start(2);
    repeat (4) @(posedge clk);
    pulse_start(5);
    wait_done("n3");
    check("n3_transfers", m_fired, 14);

    // N=4 credit limit with completions withheld during the panel
    dly = 1; rdy_mode = 0; hold = 1'b0;
    pulse_start(3);
    wait_mode(1, "panel");
    hold = 1'b1;
    repeat (12) @(negedge clk);
    check("credit_cap_transfers", m_fired, 5);
    check("credit_cap_valid", bus.o_cmd_valid, 0);
    force_one = 1'b1;
    repeat (6) @(negedge clk);
    check("credit_one_more", m_fired, 6);
    check("credit_stall_again", bus.o_cmd_valid, 0);
    hold = 1'b0;
    wait_done("credit");
    check("credit_transfers", m_fired, 30);

    // Random backpressure, delayed completions
    run(3, 3, 1, 30, "bp");

    // Completion with nothing outstanding: sticky error, counter stays zero
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("err_sticky", bus.o_err, 1);
    run(0, 1, 0, 1, "after_err");
    check("err_still", bus.o_err, 1);

    // N=2 with slow completions (stall counter exercise)
    run(1, 5, 0, 5, "n2_slow");
    check("stall_hold_after_done", bus.o_stall_cycles, m_stall);

    // Reset while in the interior pass
    dly = 2; rdy_mode = 1;
    pulse_start(3);
    wait_mode(3, "inner");
    n0 = n_done;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_no_done", n_done - n0, 0);
    check("rst_mid_busy", bus.o_busy, 0);
    check("rst_mid_err", bus.o_err, 0);

    run(2, 1, 0, 14, "recover");

    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", chk, errs + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lu_block_sched.md
Name: lu_block_sched

Overview:
Block-level task scheduler for the blocked LU engine. It walks a runtime-sized matrix of BDIM x BDIM blocks and emits one command per block operation. Each command carries a compute mode (MODE_1 to MODE_4), the block coordinates, and the cur/left/top buffer-need flags. It enforces per-step dependency barriers by tracking outstanding commands, and sits between the host control registers and the compute-lane dispatcher.

Parameters:
BDIM_BITS, 8, coordinate width; supports up to 2^BDIM_BITS blocks per dimension.
MAX_OUTSTANDING, 16, maximum issued-but-not-completed commands.
OUT_BITS, 5, outstanding counter width; must hold MAX_OUTSTANDING.

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
i_start  in  1  start pulse; sampled only in IDLE
i_bdim_m1  in  BDIM_BITS  matrix dimension in blocks minus one; latched on accepted start
o_busy  out  1  high from accepted start until o_done
o_done  out  1  one-cycle pulse at schedule completion
o_cmd_valid  out  1  command valid
i_cmd_ready  in  1  dispatcher accepts the command
o_cmd_mode  out  2  0=MODE_1 diag, 1=MODE_2 row panel, 2=MODE_3 col panel, 3=MODE_4 interior
o_cmd_k  out  BDIM_BITS  current elimination step
o_cmd_row  out  BDIM_BITS  block row
o_cmd_col  out  BDIM_BITS  block column
o_cmd_buf  out  3  {cur,left,top} buffer needs
i_cmd_done  in  1  one completion pulse per finished command
o_err  out  1  sticky error: completion received with zero outstanding
o_stall_cycles  out  32  barrier-stall cycle count (see Optional Feature)

Behaviour:
- Reset: state IDLE. All outputs 0. k, row, col and the outstanding counter cleared. Reset mid-operation abandons the schedule with no o_done.
- States: IDLE, DIAG, WAIT1, PANEL, WAIT2, INNER, WAIT3, FIN.
- IDLE: on i_start, latch N-1, set k=0, o_busy=1, go to DIAG. o_cmd_valid rises the next cycle.
- i_start outside IDLE is ignored.
- DIAG: issue (k,k), mode 0, buf 3'b100. Then go to WAIT1.
- WAIT1: when outstanding==0:
  - if k==N-1, go to FIN;
  - otherwise go to PANEL.
- PANEL: two passes, with no barrier between them.
  - Row panel: j=k+1..N-1 at (k,j), mode 1, buf 3'b110.
  - Column panel: i=k+1..N-1 at (i,k), mode 2, buf 3'b101.
  - Then go to WAIT2.
- WAIT2: when outstanding==0, go to INNER.
- INNER: row-major over i,j=k+1..N-1 at (i,j), mode 3, buf 3'b111. Then go to WAIT3.
- WAIT3: when outstanding==0, set k=k+1 and go to DIAG.
- FIN: o_done=1 for one cycle, o_busy=0, go to IDLE.
- Handshake:
  - A command transfers on o_cmd_valid && i_cmd_ready.
  - While valid and not ready, all o_cmd_* fields hold stable.
  - Throughput is one command per cycle.
- Credit: o_cmd_valid is deasserted (no new command presented) while outstanding==MAX_OUTSTANDING. A presented command is never withdrawn.
- Outstanding counter:
  - +1 on transfer, -1 on i_cmd_done; unchanged when both occur in the same cycle.
  - i_cmd_done while the counter is 0 (and no transfer that cycle): counter stays 0 and o_err sets.
  - o_err clears only on reset.
- WAIT states compare the registered counter value. A completion arriving in a WAIT state's exit cycle is still counted.
- Total command count is N(N+1)(2N+1)/6.
- N=1 (i_bdim_m1=0): a single MODE_1 command at (0,0), then done.
- Maximum coordinates wrap-free: comparisons are on BDIM_BITS values against the latched N-1.

Optional Feature:
LU_SCHED_PERF_EN:
- Defined: o_stall_cycles counts cycles spent in WAIT1/WAIT2/WAIT3 with outstanding!=0, plus cycles with o_cmd_valid && !i_cmd_ready. It clears on accepted start, saturates at all-ones, and holds after o_done.
- Undefined: o_stall_cycles is constant 0 and no counter logic is built.

Test Plan:
- Reset, then i_start with i_bdim_m1=0, ready=1, done returned 2 cycles after transfer -> one command {mode0,k0,(0,0),3'b100}; o_done pulses once; o_busy returns to 0.
- i_bdim_m1=2, ready=1, immediate completions -> exactly 14 commands in order:
  - k=0: (0,0) m0; (0,1),(0,2) m1; (1,0),(2,0) m2; (1,1),(1,2),(2,1),(2,2) m3;
  - k=1: (1,1) m0; (1,2) m1; (2,1) m2; (2,2) m3;
  - k=2: (2,2) m0;
  - then o_done.
- i_bdim_m1=3, MAX_OUTSTANDING=4, completions withheld -> o_cmd_valid stalls after 4 transfers in PANEL; after 1 done, 1 more transfer; no DIAG for k=1 until all done.
- Random i_cmd_ready backpressure -> o_cmd_* stable while valid&&!ready; total transfers for N=4 equal 30.
- i_cmd_done with counter 0 -> o_err=1, counter stays 0. Same-cycle transfer plus done -> counter unchanged. Reset mid-INNER -> all outputs 0 and no o_done.
- With LU_SCHED_PERF_EN, N=2, done delayed 5 cycles each -> o_stall_cycles equals the counted WAIT cycles. Without the macro -> reads 0.
